// File: rtl/bcd_scan_display.sv
// Eight-digit multiplexed seven-segment driver for the address/data BCD readout.
// Shadows the last loaded digits, scans one digit per refresh slot, supports blanking and blink.
module bcd_scan_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_TICKS = 1024,
  parameter bit          LZB         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_bcd,
  input  logic [15:0] data_bcd,
  input  logic        load,
  input  logic        blink_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(REFRESH_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_TICKS - 1);
  localparam logic [15:0] BlankGroup = 16'hAAAA;
  localparam logic [6:0]  SegBlank   = 7'h7F;

  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [7:0]        an_q, an_d;

  logic              tick;
  logic [15:0]       group;
  logic [1:0]        pos;
  logic [3:0]        cur_digit;
  logic              upper_zero;
  logic              lzb_blank;
  logic              blink_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      4'hB:    seg = 7'h3F;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Slot timing: prescaler, scan index and blink phase all advance off the same tick.
  always_comb begin
    tick        = (presc_q == PrescMax);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    addr_d = load ? addr_bcd : addr_q;
    data_d = load ? data_bcd : data_q;
  end

  // Digit selection: idx[2] picks the group, idx[1:0] the digit within it.
  always_comb begin
    group      = idx_q[2] ? addr_q : data_q;
    pos        = idx_q[1:0];
    cur_digit  = group[{pos, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(pos)) begin
        upper_zero = upper_zero & (group[i*4 +: 4] == 4'd0);
      end
    end
    lzb_blank   = LZB && (pos != 2'd0) && upper_zero;
    blink_blank = blink_en && blink_ph_q;
  end

  always_comb begin
    seg_d = (blink_blank || lzb_blank) ? SegBlank : seg_decode(cur_digit);
    dp_d  = ~((idx_q == 3'd4) && !blink_blank);
    an_d  = ~(8'b1 << idx_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      addr_q      <= BlankGroup;
      data_q      <= BlankGroup;
      seg_q       <= SegBlank;
      dp_q        <= 1'b1;
      an_q        <= 8'hFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: two instances (LZB on / off, different blink periods)
// share the stimulus; each expected value comes from hand tables or the slot-timing arithmetic.
module tb_bcd_scan_display;

  localparam int unsigned Rd = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        blink_en = 1'b0;
  logic [15:0] addr_bcd = 16'h0000;
  logic [15:0] data_bcd = 16'h0000;
  logic [6:0]  seg_n, seg2_n;
  logic        dp_n, dp2_n;
  logic [7:0]  an_n, an2_n;

  int checks = 0;
  int errors = 0;
  int edges = 0;

  logic [7:0] seg_tab [8] = '{8'h12, 8'h40, 8'h30, 8'h7F, 8'h24, 8'h79, 8'h7F, 8'h7F};
  logic [7:0] seg2_tab [8] = '{8'h12, 8'h40, 8'h30, 8'h40, 8'h24, 8'h79, 8'h40, 8'h40};
  logic [7:0] lz_tab [4] = '{8'h40, 8'h7F, 8'h7F, 8'h7F};

  bcd_scan_display #(
    .REFRESH_DIV(Rd),
    .BLINK_TICKS(2),
    .LZB        (1'b1)
  ) u_dut (
    .clock   (clock),
    .reset   (reset),
    .addr_bcd(addr_bcd),
    .data_bcd(data_bcd),
    .load    (load),
    .blink_en(blink_en),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  bcd_scan_display #(
    .REFRESH_DIV(Rd),
    .BLINK_TICKS(3),
    .LZB        (1'b0)
  ) u_dut_nolzb (
    .clock   (clock),
    .reset   (reset),
    .addr_bcd(addr_bcd),
    .data_bcd(data_bcd),
    .load    (load),
    .blink_en(blink_en),
    .seg_n   (seg2_n),
    .dp_n    (dp2_n),
    .an_n    (an2_n)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    edges++;
    #1;
  endtask

  // Output after edge e reflects slot ((e-1)/Rd) % 8, so slot k starts at e % 32 == 4k+1.
  task automatic goto_slot(input int k);
    int n = 0;
    do begin
      step();
      n++;
    end while (((edges % 32) != 4 * k + 1) && (n < 64));
  endtask

  // Blink phase shown after edge e: ticks completed by state e-1, divided by the period.
  function automatic bit phase(input int e, input int bt);
    return ((((e - 1) / int'(Rd)) / bt) % 2) == 1;
  endfunction

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_seg", {1'b0, seg_n}, 8'h7F);
    check("rst_an", an_n, 8'hFF);
    check("rst_dp", {7'b0, dp_n}, 8'h01);

    reset = 1'b0;
    edges = 0;
    step();
    check("rel_an", an_n, 8'hFE);
    check("rel_seg", {1'b0, seg_n}, 8'h7F);
    check("rel_dp", {7'b0, dp_n}, 8'h01);

    addr_bcd = 16'h0012;
    data_bcd = 16'h0305;
    load = 1'b1;
    step();
    load = 1'b0;
    check("load_lat0", {1'b0, seg_n}, 8'h7F);
    step();
    check("load_lat1", {1'b0, seg_n}, 8'h12);

    for (int k = 0; k < 8; k++) begin
      goto_slot(k);
      check($sformatf("scan_an%0d", k), an_n, ~(8'h01 << k));
      check($sformatf("scan_seg%0d", k), {1'b0, seg_n}, seg_tab[k]);
      check($sformatf("scan_dp%0d", k), {7'b0, dp_n}, (k == 4) ? 8'h00 : 8'h01);
      check($sformatf("nolzb_seg%0d", k), {1'b0, seg2_n}, seg2_tab[k]);
    end

    step();
    step();
    step();
    check("wrap_last", an_n, 8'h7F);
    step();
    check("wrap_first", an_n, 8'hFE);

    data_bcd = 16'hBBBB;
    blink_en = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        goto_slot(k);
        check($sformatf("blink_r%0d_k%0d", r, k), {1'b0, seg_n},
              phase(edges, 2) ? 8'h7F : 8'h3F);
      end
    end
    for (int r = 0; r < 3; r++) begin
      goto_slot(4);
      check($sformatf("blink_dp_r%0d", r), {7'b0, dp_n}, phase(edges, 2) ? 8'h01 : 8'h00);
      check($sformatf("blink2_dp_r%0d", r), {7'b0, dp2_n}, phase(edges, 3) ? 8'h01 : 8'h00);
      check($sformatf("blink2_seg_r%0d", r), {1'b0, seg2_n}, phase(edges, 3) ? 8'h7F : 8'h24);
    end

    blink_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto_slot(k);
      check($sformatf("steady_dash%0d", k), {1'b0, seg_n}, 8'h3F);
    end

    data_bcd = 16'hAAAA;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto_slot(k);
      check($sformatf("code_a%0d", k), {1'b0, seg_n}, 8'h7F);
    end

    data_bcd = 16'hCDEF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto_slot(k);
      check($sformatf("code_cf%0d", k), {1'b0, seg_n}, 8'h7F);
      check($sformatf("code_cf2_%0d", k), {1'b0, seg2_n}, 8'h7F);
    end

    data_bcd = 16'h0000;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto_slot(k);
      check($sformatf("zero_lzb%0d", k), {1'b0, seg_n}, lz_tab[k]);
      check($sformatf("zero_nolzb%0d", k), {1'b0, seg2_n}, 8'h40);
    end

    // Load on the tick edge that moves the scan from slot 0 to slot 1.
    goto_slot(0);
    step();
    step();
    data_bcd = 16'h0070;
    load = 1'b1;
    step();
    load = 1'b0;
    check("tickload_old", {1'b0, seg_n}, 8'h40);
    step();
    check("tickload_an", an_n, 8'hFD);
    check("tickload_seg", {1'b0, seg_n}, 8'h78);
    check("tickload_seg2", {1'b0, seg2_n}, 8'h78);

    step();
    step();
    reset = 1'b1;
    load = 1'b1;
    data_bcd = 16'h1234;
    step();
    check("midrst_seg", {1'b0, seg_n}, 8'h7F);
    check("midrst_an", an_n, 8'hFF);
    check("midrst_dp", {7'b0, dp_n}, 8'h01);
    reset = 1'b0;
    load = 1'b0;
    edges = 0;
    step();
    check("postrst_an", an_n, 8'hFE);
    check("postrst_seg", {1'b0, seg_n}, 8'h7F);
    for (int k = 1; k < 8; k++) begin
      goto_slot(k);
      check($sformatf("postrst_an%0d", k), an_n, ~(8'h01 << k));
      check($sformatf("postrst_seg%0d", k), {1'b0, seg_n}, 8'h7F);
      check($sformatf("postrst_seg2_%0d", k), {1'b0, seg2_n}, 8'h7F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
